// File: rtl/shift_pipe.sv
// Two-stage pipelined SLL/SRL/SRA unit with valid/ready on both sides.
// S1 registers the operands, S2 registers the shifted result and its flags.
module shift_pipe #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_shamt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_zero,
  output logic         out_illegal
);

  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  // Handshake: a transfer happens on a side only in a cycle where both valid
  // and ready are high at the rising edge; the producer holds its payload
  // stable until then, and ready never depends on the same side's valid.

  logic         s1_valid_q, s1_valid_d;
  op_e          s1_op_q,    s1_op_d;
  logic [N-1:0] s1_a_q,     s1_a_d;
  logic [N-1:0] s1_shamt_q, s1_shamt_d;

  logic         s2_valid_q,   s2_valid_d;
  logic [N-1:0] s2_result_q,  s2_result_d;
  logic         s2_zero_q,    s2_zero_d;
  logic         s2_illegal_q, s2_illegal_d;

  logic         advance;
  logic         s1_load;
  logic         in_xfer;
  logic         shamt_big;
  logic [SW-1:0] sh;

  assign in_ready = rst_n && (!s1_valid_q || !s2_valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign advance  = !s2_valid_q || out_ready;
  // An empty S1 may accept even while S2 is stalled, otherwise that op would be lost.
  assign s1_load  = advance || !s1_valid_q;

  assign s1_valid_d = in_xfer;
  assign s1_op_d    = op_e'(in_op);
  assign s1_a_d     = in_a;
  assign s1_shamt_d = in_shamt;

  // Any set bit above the low shift field means the shift saturates.
  assign shamt_big = |s1_shamt_q[N-1:SW];
  assign sh        = s1_shamt_q[SW-1:0];

  always_comb begin
    s2_result_d  = '0;
    s2_illegal_d = 1'b0;
    case (s1_op_q)
      OP_SLL: if (!shamt_big) s2_result_d = s1_a_q << sh;
      OP_SRL: if (!shamt_big) s2_result_d = s1_a_q >> sh;
      OP_SRA: begin
        if (shamt_big) s2_result_d = {N{s1_a_q[N-1]}};
        else           s2_result_d = $signed(s1_a_q) >>> sh;
      end
      default: s2_illegal_d = 1'b1;
    endcase
  end

  assign s2_zero_d  = (s2_result_d == '0);
  assign s2_valid_d = s1_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_SLL;
      s1_a_q     <= '0;
      s1_shamt_q <= '0;
    end else if (s1_load) begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_shamt_q <= s1_shamt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_zero_q    <= 1'b0;
      s2_illegal_q <= 1'b0;
    end else if (advance) begin
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_zero_q    <= s2_zero_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_zero    = s2_zero_q;
  assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed cases plus a randomized stream, scored
// against a bit-by-bit shift model through an expected queue.
module tb_shift_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;

  logic [33:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready
  logic        hold_pending = 1'b0;
  logic [34:0] held;

  shift_pipe #(.N(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_illegal(out_illegal)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: apply single-bit shift steps; saturate the count at 32.
  function automatic logic [33:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] shamt);
    logic [31:0] r;
    int          n;
    r = a;
    n = (shamt >= 32) ? 32 : int'(shamt);
    if (op == 2'b11) return {1'b1, 1'b1, 32'h0};
    for (int i = 0; i < n; i++) begin
      case (op)
        2'b00:   r = r * 2;
        2'b01:   r = r / 2;
        default: r = {r[31], r[31:1]};
      endcase
    end
    return {1'b0, (r == 32'h0), r};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] shamt);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_shamt = shamt;
    #2;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      #2;
      budget++;
    end
    if (in_ready) exp_q.push_back(model(op, a, shamt));
    else check("accept_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 500) begin
      idle_cycle();
      budget++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // monitor / scoreboard
  always begin
    @(negedge clk);
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
    #2;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        check("hold_stable", 64'({out_valid, out_illegal, out_zero, out_result}), 64'(held));
      hold_pending = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) check("spurious_valid", 64'(out_valid), 64'd0);
          else check("scoreboard", 64'({out_illegal, out_zero, out_result}), 64'(exp_q.pop_front()));
        end else begin
          hold_pending = 1'b1;
          held = {out_valid, out_illegal, out_zero, out_result};
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [1:0]  op;
    logic [31:0] a, sh;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_shamt = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_outputs", 64'({out_illegal, out_zero, out_result}), 64'd0);
    #1 rst_n = 1'b1;
    #1 check("release_in_ready", 64'(in_ready), 64'd1);

    // latency on an empty pipe
    send(2'b00, 32'h0000_0001, 32'd31);
    check("lat_edge0", 64'(out_valid), 64'd0);
    idle_cycle();
    check("lat_edge1", 64'(out_valid), 64'd0);
    idle_cycle();
    check("lat_edge2_valid", 64'(out_valid), 64'd1);
    check("lat_edge2_data", 64'({out_zero, out_result}), 64'({1'b0, 32'h8000_0000}));
    drain();

    // saturating shift amounts
    send(2'b00, 32'hFFFF_FFFF, 32'd32);
    send(2'b01, 32'hFFFF_FFFF, 32'h0001_0000);
    send(2'b10, 32'h8000_0000, 32'h100);
    send(2'b10, 32'h7FFF_FFFF, 32'd40);
    drain();

    // back-to-back mixed ops, one result per cycle
    send(2'b01, 32'hF000_000F, 32'd4);
    send(2'b10, 32'hF000_000F, 32'd4);
    send(2'b11, 32'h1234_5678, 32'd3);
    check("stream0", 64'({out_valid, out_illegal, out_result}), 64'({2'b10, 32'h0F00_0000}));
    idle_cycle();
    check("stream1", 64'({out_valid, out_illegal, out_result}), 64'({2'b10, 32'hFF00_0000}));
    idle_cycle();
    check("stream2", 64'({out_valid, out_illegal, out_zero, out_result}), 64'({3'b111, 32'h0}));
    drain();

    // backpressure: A and B fill the pipe, C is refused
    rdy_mode = 2;
    idle_cycle();
    send(2'b00, 32'h0000_1234, 32'd4);
    send(2'b01, 32'hABCD_0000, 32'd8);
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b10; in_a = 32'h8000_0010; in_shamt = 32'd4;
    #2;
    check("bp_c_blocked", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_a", 64'({out_valid, out_result}), 64'({1'b1, 32'h0001_2340}));
      @(negedge clk);
      #2;
    end
    rdy_mode = 1;
    send(2'b10, 32'h8000_0010, 32'd4);
    drain();

    // reset with two ops in flight
    rdy_mode = 2;
    idle_cycle();
    send(2'b00, 32'h0000_00FF, 32'd1);
    send(2'b01, 32'h0000_FF00, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({out_valid, out_illegal, out_zero, out_result}), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    #1 check("midrst_release", 64'(in_ready), 64'd1);
    rdy_mode = 1;
    send(2'b10, 32'hC000_0000, 32'd2);
    drain();

    // randomized regression
    rdy_mode = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    sh = $urandom_range(0, 31);
        2:       sh = $urandom_range(32, 63);
        default: sh = $urandom;
      endcase
      send(op, a, sh);
    end
    rdy_mode = 1;
    drain();
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
